fetch_stage: RTL and testbench

- IF stage plus IF/ID pipeline register of the pipelined MIPS core, directly upstream of the decode-stage control unit.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word and PC+4 for decode.
- Applies redirects resolved in decode (J/JAL, JR, taken branch), hazard stalls, and a sticky SYSCALL halt. No branch delay slot: the wrong-path fetch is squashed.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core.
// Holds the PC and drives the instruction-memory address.
// Registers the fetched word and its PC+4 for decode.
// Applies redirects resolved in decode: JR, then J/JAL, then taken branch.
// There is no branch delay slot, so any redirect squashes the wrong-path word in IF/ID.
// Also applies hazard stalls and a sticky SYSCALL halt that only reset clears.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misaligned
);

  // Fetch is either running or frozen by SYSCALL until reset.
  typedef enum logic {
    RUN,
    HALTED
  } fetchState_e;

  // Jump encodings coming from decode. The encoding 2'b11 is treated as "no jump".
  localparam logic [1:0] JUMP_J  = 2'b01;
  localparam logic [1:0] JUMP_JR = 2'b10;

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifIdInstr_q, ifIdInstr_d;
  logic [31:0] ifIdPcPlus4_q, ifIdPcPlus4_d;
  logic        ifIdValid_q, ifIdValid_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] pcPlus4;
  logic [31:0] jrAligned;
  logic [31:0] jAddr;
  logic [31:0] branchAligned;

  // Candidate next-PC values.
  // PC+4 wraps naturally at 2^32.
  // The J target takes its upper nibble from the PC+4 of the jump instruction itself,
  // which at this point is the one sitting in IF/ID.
  always_comb begin
    pcPlus4       = pc_q + 32'd4;
    jrAligned     = {jr_target[31:2], 2'b00};
    jAddr         = {ifIdPcPlus4_q[31:28], jump_index, 2'b00};
    branchAligned = {branch_target[31:2], 2'b00};
  end

  // Next-state selection, with priority: halt > stall > JR > J > branch > sequential.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifIdInstr_d   = ifIdInstr_q;
    ifIdPcPlus4_d = ifIdPcPlus4_q;
    ifIdValid_d   = ifIdValid_q;
    misaligned_d  = 1'b0;

    if (state_q == HALTED || halt) begin
      // Once halted, fetch is frozen and only bubbles reach decode.
      state_d     = HALTED;
      ifIdInstr_d = NOP_WORD;
      ifIdValid_d = 1'b0;
    end else if (stall) begin
      // Hold everything. The hazard unit keeps redirects asserted until the stall drops.
      state_d = RUN;
    end else if (jump == JUMP_JR) begin
      pc_d          = jrAligned;
      ifIdInstr_d   = NOP_WORD;
      ifIdPcPlus4_d = pcPlus4;
      ifIdValid_d   = 1'b0;
      misaligned_d  = |jr_target[1:0];
    end else if (jump == JUMP_J) begin
      pc_d          = jAddr;
      ifIdInstr_d   = NOP_WORD;
      ifIdPcPlus4_d = pcPlus4;
      ifIdValid_d   = 1'b0;
    end else if (branch_taken) begin
      pc_d          = branchAligned;
      ifIdInstr_d   = NOP_WORD;
      ifIdPcPlus4_d = pcPlus4;
      ifIdValid_d   = 1'b0;
      misaligned_d  = |branch_target[1:0];
    end else begin
      pc_d          = pcPlus4;
      ifIdInstr_d   = imem_rdata;
      ifIdPcPlus4_d = pcPlus4;
      ifIdValid_d   = 1'b1;
    end
  end

  // State, PC and IF/ID registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      ifIdInstr_q   <= NOP_WORD;
      ifIdPcPlus4_q <= RESET_PC;
      ifIdValid_q   <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifIdInstr_q   <= ifIdInstr_d;
      ifIdPcPlus4_q <= ifIdPcPlus4_d;
      ifIdValid_q   <= ifIdValid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // All outputs come straight from registers.
  // The only combinational output is imem_addr, which is the PC itself.
  always_comb begin
    imem_addr      = pc_q;
    if_id_instr    = ifIdInstr_q;
    if_id_pc_plus4 = ifIdPcPlus4_q;
    if_id_valid    = ifIdValid_q;
    halted         = (state_q == HALTED);
    misaligned     = misaligned_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// A table of vectors is applied in order, followed by hand-written halt and J-nibble sequences.
// Expected values are queued when each vector is driven, then popped and compared after the edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic [1:0]  jump;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        halted;
  logic        misaligned;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        halt;
    logic [1:0]  jump;
    logic [25:0] jumpIndex;
    logic [31:0] jrTarget;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expPp4;
    logic        expValid;
    logic        expHalted;
    logic        expMis;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  vec_t vecs[23];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-memory model: one fixed word at the reset PC, an address-derived pattern elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return a ^ 32'hA5C3_0F96;
  endfunction

  always_comb imem_rdata = imem(imem_addr);

  function automatic vec_t mkVec(
    input logic rs, input logic st, input logic hl, input logic [1:0] jp,
    input logic [25:0] ji, input logic [31:0] jr, input logic bt, input logic [31:0] btg,
    input logic [31:0] ePc, input logic [31:0] eIn, input logic [31:0] eP4,
    input logic eV, input logic eH, input logic eM);
    vec_t v;
    v.rst = rs; v.stall = st; v.halt = hl; v.jump = jp; v.jumpIndex = ji;
    v.jrTarget = jr; v.branchTaken = bt; v.branchTarget = btg;
    v.expPc = ePc; v.expInstr = eIn; v.expPp4 = eP4;
    v.expValid = eV; v.expHalted = eH; v.expMis = eM;
    return v;
  endfunction

  // Vector with no control inputs asserted (sequential fetch).
  function automatic vec_t seqVec(
    input logic [31:0] ePc, input logic [31:0] eIn, input logic [31:0] eP4);
    return mkVec(0, 0, 0, 2'b00, 26'h0, 32'h0, 0, 32'h0, ePc, eIn, eP4, 1, 0, 0);
  endfunction

  task automatic applyStimulus(input int id, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; stall = v.stall; halt = v.halt; jump = v.jump;
    jump_index = v.jumpIndex; jr_target = v.jrTarget;
    branch_taken = v.branchTaken; branch_target = v.branchTarget;
    e.id = id; e.pc = v.expPc; e.instr = v.expInstr; e.pp4 = v.expPp4;
    e.valid = v.expValid; e.halted = v.expHalted; e.mis = v.expMis;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic checkField(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL vec%0d %s: got %h, expected %h", id, name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard: queue empty, got none, expected one entry");
      return;
    end
    e = expQ.pop_front();
    checkField(e.id, "imem_addr", imem_addr, e.pc);
    checkField(e.id, "if_id_instr", if_id_instr, e.instr);
    checkField(e.id, "if_id_pc_plus4", if_id_pc_plus4, e.pp4);
    checkField(e.id, "if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
    checkField(e.id, "halted", {31'b0, halted}, {31'b0, e.halted});
    checkField(e.id, "misaligned", {31'b0, misaligned}, {31'b0, e.mis});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; halt = 1'b0; jump = 2'b00; jump_index = 26'h0;
    jr_target = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;

    vecs[0]  = mkVec(1, 0, 0, 2'b00, 26'h0, 32'h0, 0, 32'h0,
                     32'h0040_0000, 32'h0, 32'h0040_0000, 0, 0, 0);
    vecs[1]  = seqVec(32'h0040_0004, 32'h2008_0005, 32'h0040_0004);
    vecs[2]  = seqVec(32'h0040_0008, imem(32'h0040_0004), 32'h0040_0008);
    vecs[3]  = mkVec(0, 0, 0, 2'b01, 26'h010_0010, 32'h0, 0, 32'h0,
                     32'h0040_0040, 32'h0, 32'h0040_000C, 0, 0, 0);
    vecs[4]  = seqVec(32'h0040_0044, imem(32'h0040_0040), 32'h0040_0044);
    vecs[5]  = mkVec(0, 0, 0, 2'b10, 26'h0, 32'h0040_0103, 1, 32'h0040_0200,
                     32'h0040_0100, 32'h0, 32'h0040_0048, 0, 0, 1);
    vecs[6]  = seqVec(32'h0040_0104, imem(32'h0040_0100), 32'h0040_0104);
    vecs[7]  = mkVec(0, 1, 0, 2'b00, 26'h0, 32'h0, 1, 32'h0040_0300,
                     32'h0040_0104, imem(32'h0040_0100), 32'h0040_0104, 1, 0, 0);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = mkVec(0, 0, 0, 2'b00, 26'h0, 32'h0, 1, 32'h0040_0300,
                     32'h0040_0300, 32'h0, 32'h0040_0108, 0, 0, 0);
    vecs[11] = seqVec(32'h0040_0304, imem(32'h0040_0300), 32'h0040_0304);
    vecs[12] = mkVec(0, 0, 0, 2'b00, 26'h0, 32'h0, 1, 32'h0040_0502,
                     32'h0040_0500, 32'h0, 32'h0040_0308, 0, 0, 1);
    vecs[13] = mkVec(0, 0, 0, 2'b11, 26'h3FF_FFFF, 32'h1234_5678, 0, 32'h0,
                     32'h0040_0504, imem(32'h0040_0500), 32'h0040_0504, 1, 0, 0);
    vecs[14] = mkVec(0, 0, 0, 2'b10, 26'h0, 32'hFFFF_FFFC, 0, 32'h0,
                     32'hFFFF_FFFC, 32'h0, 32'h0040_0508, 0, 0, 0);
    vecs[15] = seqVec(32'h0000_0000, imem(32'hFFFF_FFFC), 32'h0000_0000);
    vecs[16] = seqVec(32'h0000_0004, imem(32'h0000_0000), 32'h0000_0004);
    vecs[17] = mkVec(0, 1, 1, 2'b00, 26'h0, 32'h0, 1, 32'h0000_0800,
                     32'h0000_0004, 32'h0, 32'h0000_0004, 0, 1, 0);
    vecs[18] = mkVec(0, 0, 0, 2'b10, 26'h0, 32'h0000_0101, 0, 32'h0,
                     32'h0000_0004, 32'h0, 32'h0000_0004, 0, 1, 0);
    vecs[19] = mkVec(0, 0, 0, 2'b00, 26'h0, 32'h0, 0, 32'h0,
                     32'h0000_0004, 32'h0, 32'h0000_0004, 0, 1, 0);
    vecs[20] = mkVec(1, 1, 1, 2'b10, 26'h0, 32'h0000_0203, 1, 32'h0,
                     32'h0040_0000, 32'h0, 32'h0040_0000, 0, 0, 0);
    vecs[21] = seqVec(32'h0040_0004, 32'h2008_0005, 32'h0040_0004);
    vecs[22] = mkVec(0, 0, 0, 2'b01, 26'h3FF_FFFF, 32'h0, 1, 32'h0000_0100,
                     32'h0FFF_FFFC, 32'h0, 32'h0040_0008, 0, 0, 0);

    $display("[TB] Starting table-driven vectors");
    for (int i = 0; i < 23; i++) applyStimulus(i, vecs[i]);

    // J takes its upper nibble from if_id_pc_plus4 (here 0x1...).
    $display("[TB] Starting J upper-nibble and halt sequence");
    applyStimulus(100, seqVec(32'h1000_0000, imem(32'h0FFF_FFFC), 32'h1000_0000));
    applyStimulus(101, mkVec(0, 0, 0, 2'b01, 26'h000_0004, 32'h0, 0, 32'h0,
                             32'h1000_0010, 32'h0, 32'h1000_0004, 0, 0, 0));
    applyStimulus(102, mkVec(0, 0, 1, 2'b00, 26'h0, 32'h0, 0, 32'h0,
                             32'h1000_0010, 32'h0, 32'h1000_0004, 0, 1, 0));
    // While halted, random redirects and stalls must all be ignored.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(103 + k, mkVec(0, 1'($urandom_range(0, 1)), 0, 2'($urandom_range(0, 3)),
                                   26'($urandom), $urandom, 1'($urandom_range(0, 1)), $urandom,
                                   32'h1000_0010, 32'h0, 32'h1000_0004, 0, 1, 0));
    end
    applyStimulus(110, mkVec(1, 0, 0, 2'b00, 26'h0, 32'h0, 0, 32'h0,
                             32'h0040_0000, 32'h0, 32'h0040_0000, 0, 0, 0));
    applyStimulus(111, seqVec(32'h0040_0004, 32'h2008_0005, 32'h0040_0004));

    if (expQ.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard drain: got %0d leftover entries, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
